// File: rtl/hazard_pkg.sv
// Shared hazard-control types: FSM state encoding, control bundle, decode bubble constant.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FL_W  = 3;

  // ALUop value decode uses when it turns an instruction into a bubble
  localparam logic [1:0] ALUOP_BUBBLE = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic haz_detect;
    logic id_flush;
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic pipe_hold;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN   = '{haz_detect: 1'b1, id_flush: 1'b0, pc_write: 1'b1,
                                      if_id_write: 1'b1, if_flush: 1'b0, pipe_hold: 1'b0};
  localparam hz_ctrl_t CTRL_WAIT  = '{haz_detect: 1'b1, id_flush: 1'b0, pc_write: 1'b0,
                                      if_id_write: 1'b0, if_flush: 1'b0, pipe_hold: 1'b1};
  localparam hz_ctrl_t CTRL_FLUSH = '{haz_detect: 1'b1, id_flush: 1'b1, pc_write: 1'b1,
                                      if_id_write: 1'b1, if_flush: 1'b1, pipe_hold: 1'b0};
  localparam hz_ctrl_t CTRL_LU    = '{haz_detect: 1'b0, id_flush: 1'b0, pc_write: 1'b0,
                                      if_id_write: 1'b0, if_flush: 1'b0, pipe_hold: 1'b0};
  localparam hz_ctrl_t CTRL_RST   = '{haz_detect: 1'b0, id_flush: 1'b1, pc_write: 1'b0,
                                      if_id_write: 1'b0, if_flush: 1'b1, pipe_hold: 1'b0};

  // Load in EX whose destination (non-x0) feeds a source actually read in ID
  function automatic logic load_use(input logic             mem_read,
                                    input logic [REG_W-1:0] ex_wr,
                                    input logic             use_rs1,
                                    input logic [REG_W-1:0] rs1,
                                    input logic             use_rs2,
                                    input logic [REG_W-1:0] rs2);
    load_use = mem_read && (ex_wr != '0) &&
               ((use_rs1 && (rs1 == ex_wr)) || (use_rs2 && (rs2 == ex_wr)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count events, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flush windows, dmem wait holds.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_wr,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clear,
  output logic             hazDetect_ID_EX,
  output logic             ID_Flush,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e       r_state;
  logic [FL_W-1:0] r_flush_left;

  hz_state_e       w_state_nxt;
  logic [FL_W-1:0] w_flush_left_nxt;
  hz_ctrl_t        w_ctrl;
  logic            w_load_use;
  logic            w_mem_wait;
  logic            w_redirect_acc;

  assign w_load_use = load_use(ex_MemRead, ex_wr, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

  // In MEM_WAIT only dmem_ready releases; in RUN a request without same-cycle ready stalls
  assign w_mem_wait = (r_state == ST_MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);

  // Next-state and control decode; reset forces the flush/freeze pattern asynchronously
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_left_nxt = r_flush_left;
    w_ctrl           = CTRL_RUN;
    w_redirect_acc   = 1'b0;

    unique case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_wait) begin
          w_ctrl      = CTRL_WAIT;
          w_state_nxt = ST_MEM_WAIT;
        end else if (ex_redirect) begin
          w_ctrl         = CTRL_FLUSH;
          w_redirect_acc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt      = ST_FLUSH;
            w_flush_left_nxt = FL_W'(FLUSH_CYCLES - 1);
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else if (w_load_use) begin
          w_ctrl      = CTRL_LU;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // EX holds a flushed bubble here, so a redirect seen now is stale
        w_ctrl = CTRL_FLUSH;
        if (r_flush_left <= FL_W'(1)) begin
          w_state_nxt      = ST_RUN;
          w_flush_left_nxt = '0;
        end else begin
          w_flush_left_nxt = r_flush_left - FL_W'(1);
        end
      end
      default: begin
        w_state_nxt      = ST_RUN;
        w_flush_left_nxt = '0;
      end
    endcase

    if (!rst_n) begin
      w_ctrl         = CTRL_RST;
      w_redirect_acc = 1'b0;
    end
  end

  // FSM state and remaining flush count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_flush_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_left <= w_flush_left_nxt;
    end
  end

  assign hazDetect_ID_EX = w_ctrl.haz_detect;
  assign ID_Flush        = w_ctrl.id_flush;
  assign pc_write        = w_ctrl.pc_write;
  assign if_id_write     = w_ctrl.if_id_write;
  assign if_flush        = w_ctrl.if_flush;
  assign pipe_hold       = w_ctrl.pipe_hold;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (!w_ctrl.pc_write),
    .i_clr (cnt_clear),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_redirect_acc),
    .i_clr (cnt_clear),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_CYCLES=3 and 4-bit counters.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // {hazDetect_ID_EX, ID_Flush, pc_write, if_id_write, if_flush, pipe_hold}
  localparam logic [5:0] EXP_IDLE  = 6'b101100;
  localparam logic [5:0] EXP_WAIT  = 6'b100001;
  localparam logic [5:0] EXP_FLUSH = 6'b111110;
  localparam logic [5:0] EXP_LU    = 6'b000000;
  localparam logic [5:0] EXP_RST   = 6'b010010;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_wr;
  logic             id_use_rs1, id_use_rs2, ex_MemRead, ex_redirect;
  logic             dmem_req, dmem_ready, cnt_clear;
  logic             hazDetect_ID_EX, ID_Flush, pc_write, if_id_write, if_flush, pipe_hold;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [5:0]       obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_MemRead      (ex_MemRead),
    .ex_wr           (ex_wr),
    .ex_redirect     (ex_redirect),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .cnt_clear       (cnt_clear),
    .hazDetect_ID_EX (hazDetect_ID_EX),
    .ID_Flush        (ID_Flush),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_flush        (if_flush),
    .pipe_hold       (pipe_hold),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  assign obs = {hazDetect_ID_EX, ID_Flush, pc_write, if_id_write, if_flush, pipe_hold};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_MemRead = 1'b0; ex_wr = '0; ex_redirect = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] wr, input logic use1, input logic [4:0] rs1,
                              input logic use2, input logic [4:0] rs2);
    ex_MemRead = 1'b1; ex_wr = wr;
    id_use_rs1 = use1; id_rs1 = rs1;
    id_use_rs2 = use2; id_rs2 = rs2;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check_eq("reset_outputs", 32'(obs), 32'(EXP_RST));
    check_eq("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("run_idle", 32'(obs), 32'(EXP_IDLE));

    // Load-use on rs1: one bubble
    set_load_use(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    check_eq("lu_rs1_outputs", 32'(obs), 32'(EXP_LU));
    step();
    check_eq("lu_rs1_stall_cnt", 32'(stall_cnt), 32'd1);
    idle_inputs();
    #1;
    check_eq("lu_after_bubble", 32'(obs), 32'(EXP_IDLE));

    // Destination x0 never stalls
    set_load_use(5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    #1;
    check_eq("lu_x0_no_stall", 32'(obs), 32'(EXP_IDLE));
    // Matching register but not read
    set_load_use(5'd5, 1'b0, 5'd5, 1'b0, 5'd0);
    #1;
    check_eq("lu_unused_rs1", 32'(obs), 32'(EXP_IDLE));
    // Match via rs2
    set_load_use(5'd9, 1'b1, 5'd3, 1'b1, 5'd9);
    #1;
    check_eq("lu_rs2_outputs", 32'(obs), 32'(EXP_LU));
    step();
    check_eq("lu_rs2_stall_cnt", 32'(stall_cnt), 32'd2);
    idle_inputs();

    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check_eq("clear_stall_cnt", 32'(stall_cnt), 32'd0);

    // Redirect: three flush cycles, repeat redirect inside window ignored
    ex_redirect = 1'b1;
    #1;
    check_eq("redir_c1", 32'(obs), 32'(EXP_FLUSH));
    step();
    check_eq("redir_c2_ignored", 32'(obs), 32'(EXP_FLUSH));
    step();
    check_eq("redir_c3", 32'(obs), 32'(EXP_FLUSH));
    ex_redirect = 1'b0;
    step();
    check_eq("redir_done", 32'(obs), 32'(EXP_IDLE));
    check_eq("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    check_eq("redir_stall_cnt", 32'(stall_cnt), 32'd0);

    // Same-cycle ready: no wait
    dmem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    check_eq("dmem_ready_same_cycle", 32'(obs), 32'(EXP_IDLE));
    step();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    check_eq("dmem_no_wait_after", 32'(obs), 32'(EXP_IDLE));

    // Memory wait masks redirect and load-use, then releases into the redirect
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    set_load_use(5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("mem_wait_c%0d", i + 1), 32'(obs), 32'(EXP_WAIT));
      step();
    end
    check_eq("mem_wait_stall_cnt", 32'(stall_cnt), 32'd4);
    dmem_ready = 1'b1;
    #1;
    check_eq("mem_release_redirect", 32'(obs), 32'(EXP_FLUSH));
    step();
    idle_inputs();
    check_eq("mem_release_flush_cnt", 32'(flush_cnt), 32'd2);
    #1;
    check_eq("mem_release_flush_c2", 32'(obs), 32'(EXP_FLUSH));
    step();
    check_eq("mem_release_flush_c3", 32'(obs), 32'(EXP_FLUSH));
    step();
    check_eq("mem_release_done", 32'(obs), 32'(EXP_IDLE));
    check_eq("mem_release_stall_cnt", 32'(stall_cnt), 32'd4);

    // Stall counter saturation, then clear beats increment
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    set_load_use(5'd1, 1'b1, 5'd1, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) step();
    check_eq("stall_cnt_saturated", 32'(stall_cnt), 32'd15);
    check_eq("lu_held_outputs", 32'(obs), 32'(EXP_LU));
    cnt_clear = 1'b1;
    step();
    check_eq("clear_beats_inc", 32'(stall_cnt), 32'd0);
    idle_inputs();

    // Reset asynchronously in the middle of a memory wait
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step();
    check_eq("pre_reset_wait", 32'(obs), 32'(EXP_WAIT));
    check_eq("pre_reset_stall_cnt", 32'(stall_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", 32'(obs), 32'(EXP_RST));
    check_eq("async_reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("async_reset_flush_cnt", 32'(flush_cnt), 32'd0);
    dmem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_reset_run", 32'(obs), 32'(EXP_IDLE));
    step();
    check_eq("post_reset_run_edge", 32'(obs), 32'(EXP_IDLE));
    check_eq("post_reset_stall_cnt", 32'(stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
